// File: rtl/usb_spi_bridge_pkg.sv
// Shared constants for the USB-CDC to SPI bridge: command opcodes, error byte
// and the command FSM state encoding.
package usb_spi_bridge_pkg;

  localparam logic [7:0] OP_CS_HIGH = 8'h10;
  localparam logic [7:0] OP_CS_LOW  = 8'h11;
  localparam logic [7:0] OP_XFER    = 8'h20;
  localparam logic [7:0] ERR_BYTE   = 8'hEE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    SHIFT = 3'd3,
    PUSH  = 3'd4
  } state_t;

endpackage

// File: rtl/usb_spi_bridge_spi_shifter.sv
// Mode-0 SPI byte shifter with SCK_DIV prescaler and a start/done handshake.
// USB_SPI_BRIDGE_LOOPBACK_EN feeds mosi back in as the sampled bit.
module spi_shifter #(
  parameter int SCK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  logic       busy;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sreg;
  logic       tick;
  logic       in_bit;

  assign tick = busy && (div_cnt == 8'(SCK_DIV - 1));

`ifdef USB_SPI_BRIDGE_LOOPBACK_EN
  assign in_bit = mosi;
`else
  assign in_bit = miso;
`endif

  // Completes on the 8th falling edge, by which time the last bit is in sreg.
  assign done    = tick && sck && (bit_cnt == 3'd7);
  assign rx_byte = sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      sreg    <= 8'd0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      sreg    <= tx_byte;
      sck     <= 1'b0;
      mosi    <= tx_byte[7];
    end else if (busy) begin
      if (tick) begin
        div_cnt <= 8'd0;
        sck     <= ~sck;
        // Rising edge samples; falling edge presents the next tx bit.
        if (!sck) begin
          sreg <= {sreg[6:0], in_bit};
        end else if (bit_cnt == 3'd7) begin
          busy <= 1'b0;
          mosi <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          mosi    <= sreg[7];
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/usb_spi_bridge.sv
// Command-stream driven SPI master bridging USB CDC OUT/IN byte streams.
// Define USB_SPI_BRIDGE_LOOPBACK_EN to echo XFER data internally (miso ignored).
module usb_spi_bridge
  import usb_spi_bridge_pkg::*;
#(
  parameter int SCK_DIV = 1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       sck_o,
  output logic       csn_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  state_t     state, state_n;
  logic [8:0] count, count_n;
  logic [7:0] in_data_n;
  logic       csn_n;
  logic       start;
  logic       done;
  logic [7:0] rx_byte;
  logic       accept;

  // Ready is gated by reset so it reads low while held in reset.
  assign out_ready_o = rstn_i && (state == IDLE || state == LEN || state == DATA);
  assign in_valid_o  = (state == PUSH);
  assign accept      = out_valid_i && out_ready_o;

  spi_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .start   (start),
    .tx_byte (out_data_i),
    .miso    (miso_i),
    .sck     (sck_o),
    .mosi    (mosi_o),
    .done    (done),
    .rx_byte (rx_byte)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      count     <= 9'd0;
      in_data_o <= 8'd0;
      csn_o     <= 1'b1;
    end else begin
      state     <= state_n;
      count     <= count_n;
      in_data_o <= in_data_n;
      csn_o     <= csn_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    in_data_n = in_data_o;
    csn_n     = csn_o;
    start     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        case (out_data_i)
          OP_CS_HIGH: csn_n = 1'b1;
          OP_CS_LOW:  csn_n = 1'b0;
          OP_XFER:    state_n = LEN;
          default: begin
            in_data_n = ERR_BYTE;
            state_n   = PUSH;
          end
        endcase
      end
      LEN: if (accept) begin
        count_n = (out_data_i == 8'd0) ? 9'd256 : {1'b0, out_data_i};
        state_n = DATA;
      end
      DATA: if (accept) begin
        start   = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: if (done) begin
        in_data_n = rx_byte;
        state_n   = PUSH;
      end
      PUSH: if (in_ready_i) begin
        // Error bytes arrive with count 0; clamp so the count never wraps.
        if (count > 9'd1) begin
          count_n = count - 9'd1;
          state_n = DATA;
        end else begin
          count_n = 9'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_spi_bridge.sv
// Directed, table-driven bench for usb_spi_bridge with SCK_DIV=1 and a simple
// SPI slave model on miso_i (pattern shifter or mosi echo).
module tb_usb_spi_bridge;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] out_data_i = 8'd0;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b0;
  logic       sck_o;
  logic       csn_o;
  logic       mosi_o;
  logic       miso_i;

  int total = 0;
  int bad = 0;

  logic       loopback_mode = 1'b0;
  logic [7:0] miso_pattern = 8'h00;
  int         miso_base = 0;
  int         rise_count = 0;
  int         fall_count = 0;
  int         in_count = 0;
  logic [7:0] mosi_cap = 8'h00;
  int         miso_idx;

  usb_spi_bridge #(.SCK_DIV(1)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .sck_o       (sck_o),
    .csn_o       (csn_o),
    .mosi_o      (mosi_o),
    .miso_i      (miso_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave model: present pattern MSB first, advancing on each sck falling edge.
  assign miso_idx = fall_count - miso_base;
  assign miso_i = loopback_mode ? mosi_o :
                  (miso_idx >= 0 && miso_idx < 8) ? miso_pattern[3'(7 - miso_idx)] : 1'b0;

  always @(posedge sck_o) begin
    rise_count = rise_count + 1;
    mosi_cap   = {mosi_cap[6:0], mosi_o};
  end

  always @(negedge sck_o) fall_count = fall_count + 1;

  always @(negedge clk_i) if (rstn_i && in_valid_o && in_ready_i) in_count = in_count + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int n;
    bit ok;
    ok = 1'b0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    for (n = 0; n < 2000; n++) begin
      if (out_ready_o) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    out_valid_i = 1'b0;
    if (!ok) check_output("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic receive_byte(output logic [7:0] b);
    int n;
    bit ok;
    ok = 1'b0;
    b = 8'h00;
    for (n = 0; n < 2000; n++) begin
      if (in_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      b = in_data_o;
      in_ready_i = 1'b1;
      tick();
      in_ready_i = 1'b0;
    end else begin
      check_output("recv_timeout", 32'd0, 32'd1);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       exp_csn;
    logic       exp_err;
  } vec_t;

  initial begin
    vec_t       vecs[7];
    logic [7:0] b;
    logic [7:0] d0;
    int         r0, in0, n, errs, viol;

    vecs[0] = '{8'h11, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'h10, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b1};

    // Reset values while held in reset
    tick(); tick();
    check_output("rst_csn", 32'(csn_o), 32'd1);
    check_output("rst_sck", 32'(sck_o), 32'd0);
    check_output("rst_mosi", 32'(mosi_o), 32'd0);
    check_output("rst_in_valid", 32'(in_valid_o), 32'd0);
    check_output("rst_in_data", 32'(in_data_o), 32'h00);
    check_output("rst_out_ready", 32'(out_ready_o), 32'd0);
    rstn_i = 1'b1;
    #1;
    check_output("post_rst_ready", 32'(out_ready_o), 32'd1);

    // Command table: chip-select control and unknown opcodes
    r0 = rise_count;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].cmd);
      check_output($sformatf("vec%0d_csn", i), 32'(csn_o), 32'(vecs[i].exp_csn));
      check_output($sformatf("vec%0d_in_valid", i), 32'(in_valid_o), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) begin
        receive_byte(b);
        check_output($sformatf("vec%0d_err_byte", i), 32'(b), 32'hEE);
      end
    end
    check_output("no_sck_on_cmds", 32'(rise_count - r0), 32'd0);

    // Single-byte XFER: 0xA5 out, slave returns 0x3C
    apply_stimulus(8'h11);
    loopback_mode = 1'b0;
    miso_pattern  = 8'h3C;
    miso_base     = fall_count;
    r0            = rise_count;
    apply_stimulus(8'h20);
    apply_stimulus(8'h01);
    apply_stimulus(8'hA5);
    n = 0;
    while (!in_valid_o && n < 100) begin
      tick();
      n++;
    end
    check_output("xfer_cycles", 32'(n), 32'd16);
    check_output("xfer_sck_pulses", 32'(rise_count - r0), 32'd8);
    check_output("xfer_mosi_bits", 32'(mosi_cap), 32'hA5);
`ifdef USB_SPI_BRIDGE_LOOPBACK_EN
    check_output("xfer_rx", 32'(in_data_o), 32'hA5);
`else
    check_output("xfer_rx", 32'(in_data_o), 32'h3C);
`endif
    check_output("xfer_csn_kept", 32'(csn_o), 32'd0);

    // Back-pressure: 50 stalled cycles in PUSH with an OUT byte offered
    d0 = in_data_o;
    viol = 0;
    out_data_i  = 8'h10;
    out_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!in_valid_o || in_data_o !== d0 || out_ready_o || sck_o) viol++;
    end
    out_valid_i = 1'b0;
    check_output("stall_violations", 32'(viol), 32'd0);
    check_output("stall_csn", 32'(csn_o), 32'd0);
    receive_byte(b);
    check_output("stall_release_data", 32'(b), 32'(d0));
    check_output("back_to_idle_ready", 32'(out_ready_o), 32'd1);

    // Two-byte XFER with echoing slave, then an opcode proves the FSM is idle
    loopback_mode = 1'b1;
    apply_stimulus(8'h20);
    apply_stimulus(8'h02);
    apply_stimulus(8'h5A);
    receive_byte(b);
    check_output("len2_byte0", 32'(b), 32'h5A);
    apply_stimulus(8'hC3);
    receive_byte(b);
    check_output("len2_byte1", 32'(b), 32'hC3);
    apply_stimulus(8'h77);
    receive_byte(b);
    check_output("len2_then_idle", 32'(b), 32'hEE);

    // L=0 means 256 bytes
    in0 = in_count;
    errs = 0;
    apply_stimulus(8'h20);
    apply_stimulus(8'h00);
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(8'(i));
      receive_byte(b);
      if (b !== 8'(i)) errs++;
    end
    check_output("len256_order_errors", 32'(errs), 32'd0);
    check_output("len256_count", 32'(in_count - in0), 32'd256);
    apply_stimulus(8'h55);
    receive_byte(b);
    check_output("len256_then_idle", 32'(b), 32'hEE);

    // Reset asserted at the 4th sck rising edge of a transfer
    loopback_mode = 1'b0;
    miso_pattern  = 8'hFF;
    miso_base     = fall_count;
    apply_stimulus(8'h11);
    apply_stimulus(8'h20);
    apply_stimulus(8'h01);
    r0  = rise_count;
    in0 = in_count;
    apply_stimulus(8'hFF);
    n = 0;
    while (rise_count < r0 + 4 && n < 200) begin
      tick();
      n++;
    end
    check_output("abort_reached_4th_rise", 32'(rise_count - r0), 32'd4);
    rstn_i = 1'b0;
    #1;
    check_output("abort_csn", 32'(csn_o), 32'd1);
    check_output("abort_sck", 32'(sck_o), 32'd0);
    check_output("abort_mosi", 32'(mosi_o), 32'd0);
    check_output("abort_in_valid", 32'(in_valid_o), 32'd0);
    check_output("abort_in_data", 32'(in_data_o), 32'h00);
    check_output("abort_out_ready", 32'(out_ready_o), 32'd0);
    tick();
    rstn_i = 1'b1;
    #1;
    check_output("abort_release_ready", 32'(out_ready_o), 32'd1);
    r0 = rise_count;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (in_valid_o) viol++;
    end
    check_output("abort_no_in_valid", 32'(viol), 32'd0);
    check_output("abort_no_in_byte", 32'(in_count - in0), 32'd0);
    check_output("abort_no_sck", 32'(rise_count - r0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
